// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared types for the edge-detector pipeline control path.
//   seq_state_t : pass sequencer states
//   fb_sel_t    : frame-buffer select code (input / scratch A / scratch B)
// No ports; imported with `import edge_pkg::*;`.
// -----------------------------------------------------------------------------
package edge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        GAP,
        FINISH,
        ABORT
    } seq_state_t;

    typedef logic [1:0] fb_sel_t;

    localparam fb_sel_t FB_INPUT     = 2'd0;
    localparam fb_sel_t FB_SCRATCH_A = 2'd1;
    localparam fb_sel_t FB_SCRATCH_B = 2'd2;

endpackage

// File: rtl/pass_sequencer_if.sv
// -----------------------------------------------------------------------------
// pass_sequencer_if
// Bundles the host handshake and kernel control signals of pass_sequencer.
//   master : the sequencer (drives kernel run/clear, status and buffer selects)
//   slave  : host + kernels (drive start, abort and kern_done)
// Signals: start, abort, busy, frame_done, aborted, kern_run, kern_done,
//          kern_rst_n, pass_idx, src_sel, dst_sel, out_sel and, when
//          PASS_SEQ_CYCLE_CNT_EN is defined, frame_cycles.
// Parameters must match those of the pass_sequencer instance it connects to.
// -----------------------------------------------------------------------------
interface pass_sequencer_if #(
    parameter int NUM_PASSES = 3,
    parameter int PASS_BITS  = 2,
    parameter int CNT_BITS   = 32
);
    import edge_pkg::*;

    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  frame_done;
    logic                  aborted;
    logic [NUM_PASSES-1:0] kern_run;
    logic [NUM_PASSES-1:0] kern_done;
    logic                  kern_rst_n;
    logic [PASS_BITS-1:0]  pass_idx;
    fb_sel_t               src_sel;
    fb_sel_t               dst_sel;
    fb_sel_t               out_sel;
`ifdef PASS_SEQ_CYCLE_CNT_EN
    logic [CNT_BITS-1:0]   frame_cycles;
`endif

    modport master (
        input  start, abort, kern_done,
        output busy, frame_done, aborted, kern_run, kern_rst_n,
               pass_idx, src_sel, dst_sel, out_sel
`ifdef PASS_SEQ_CYCLE_CNT_EN
        , output frame_cycles
`endif
    );

    modport slave (
        output start, abort, kern_done,
        input  busy, frame_done, aborted, kern_run, kern_rst_n,
               pass_idx, src_sel, dst_sel, out_sel
`ifdef PASS_SEQ_CYCLE_CNT_EN
        , input frame_cycles
`endif
    );

endinterface

// File: rtl/pass_sequencer_fb_sel_sched.sv
// -----------------------------------------------------------------------------
// fb_sel_sched
// Combinational map from a pass index to its frame-buffer selects.
// Pass 0 reads the input frame; later passes read what the previous pass
// wrote. Destinations alternate scratch A / scratch B, so a pass never
// reads and writes the same buffer.
//   pass_idx : pass index (in)
//   src_sel  : buffer the pass reads (out)
//   dst_sel  : buffer the pass writes (out)
// -----------------------------------------------------------------------------
module fb_sel_sched
    import edge_pkg::*;
#(
    parameter int PASS_BITS = 2
) (
    input  logic [PASS_BITS-1:0] pass_idx,
    output fb_sel_t              src_sel,
    output fb_sel_t              dst_sel
);

    always_comb begin
        dst_sel = pass_idx[0] ? FB_SCRATCH_B : FB_SCRATCH_A;
        if (pass_idx == '0) begin
            src_sel = FB_INPUT;
        end else begin
            // Read back the buffer the previous (opposite-parity) pass wrote.
            src_sel = pass_idx[0] ? FB_SCRATCH_A : FB_SCRATCH_B;
        end
    end

endmodule

// File: rtl/pass_sequencer.sv
// -----------------------------------------------------------------------------
// pass_sequencer
// Frame-level controller: runs NUM_PASSES pixel kernels one after another
// over a whole frame, clearing kernel state before each frame and steering
// the frame-buffer selects so each pass reads and writes distinct buffers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pass_sequencer_if.master (start/abort in, kernel run/clear,
//                status pulses, pass index and buffer selects out)
// Optional feature (macro PASS_SEQ_CYCLE_CNT_EN): frame cycle counter,
// reported on bus.frame_cycles as the number of busy cycles from CLEAR
// through FINISH inclusive, saturating at all-ones.
// All outputs are registered.
// -----------------------------------------------------------------------------
module pass_sequencer
    import edge_pkg::*;
#(
    parameter int NUM_PASSES = 3,
    parameter int PASS_BITS  = 2,
    parameter int CNT_BITS   = 32
) (
    input logic              clk,
    input logic              rst_n,
    pass_sequencer_if.master bus
);

    localparam logic [NUM_PASSES-1:0] RUN_ONE  = NUM_PASSES'(1);
    localparam logic [PASS_BITS-1:0]  LAST_IDX = PASS_BITS'(NUM_PASSES - 1);

    seq_state_t           state;
    logic [PASS_BITS-1:0] sched_idx;
    fb_sel_t              sched_src;
    fb_sel_t              sched_dst;
    logic                 start_take;

    // Selects are loaded on IDLE->CLEAR (pass 0) and RUN->GAP (next pass).
    assign sched_idx  = (state == IDLE) ? '0 : bus.pass_idx + PASS_BITS'(1);
    assign start_take = (state == IDLE) && bus.start && !bus.abort;

    fb_sel_sched #(
        .PASS_BITS (PASS_BITS)
    ) u_sched (
        .pass_idx (sched_idx),
        .src_sel  (sched_src),
        .dst_sel  (sched_dst)
    );

    // NOTE: every output is updated together with the state transition that
    // produces it, so the value seen in a state is already registered when
    // that state begins; nothing reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.aborted    <= 1'b0;
            bus.kern_run   <= '0;
            bus.kern_rst_n <= 1'b1;
            bus.pass_idx   <= '0;
            bus.src_sel    <= FB_INPUT;
            bus.dst_sel    <= FB_SCRATCH_A;
            bus.out_sel    <= FB_INPUT;
        end else begin
            // Pulse-type outputs fall back to idle unless a transition below
            // raises them for exactly one cycle.
            bus.frame_done <= 1'b0;
            bus.aborted    <= 1'b0;
            bus.kern_rst_n <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start_take) begin
                        state          <= CLEAR;
                        bus.busy       <= 1'b1;
                        bus.kern_rst_n <= 1'b0;
                        bus.pass_idx   <= '0;
                        bus.src_sel    <= sched_src;
                        bus.dst_sel    <= sched_dst;
                    end
                end

                CLEAR, RUN, GAP: begin
                    if (bus.abort) begin
                        state          <= ABORT;
                        bus.kern_run   <= '0;
                        bus.kern_rst_n <= 1'b0;
                        bus.aborted    <= 1'b1;
                    end else if (state != RUN) begin
                        state        <= RUN;
                        bus.kern_run <= RUN_ONE << bus.pass_idx;
                    end else if (bus.kern_done[bus.pass_idx]) begin
                        // Done marks the last-pixel cycle of the active kernel.
                        bus.kern_run <= '0;
                        if (bus.pass_idx == LAST_IDX) begin
                            state          <= FINISH;
                            bus.frame_done <= 1'b1;
                            bus.out_sel    <= bus.dst_sel;
                        end else begin
                            state        <= GAP;
                            bus.pass_idx <= sched_idx;
                            bus.src_sel  <= sched_src;
                            bus.dst_sel  <= sched_dst;
                        end
                    end
                end

                FINISH, ABORT: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef PASS_SEQ_CYCLE_CNT_EN
    logic [CNT_BITS-1:0] cyc_cnt;
    logic                finish_take;

    assign finish_take = (state == RUN) && !bus.abort &&
                         bus.kern_done[bus.pass_idx] && (bus.pass_idx == LAST_IDX);

    // cyc_cnt holds the number of busy cycles elapsed including the current
    // one; the CLEAR cycle counts as 1, so the value captured on entry to
    // FINISH includes the FINISH cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt          <= '0;
            bus.frame_cycles <= '0;
        end else begin
            if (start_take) begin
                cyc_cnt <= CNT_BITS'(1);
            end else if (state != IDLE && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + CNT_BITS'(1);
            end
            if (finish_take) begin
                bus.frame_cycles <= (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CNT_BITS'(1);
            end
        end
    end
`endif

endmodule

// File: doc/pass_sequencer.md
Name: pass_sequencer

Overview:
Frame-level controller for the edge-detector pipeline. It runs the NUM_PASSES pixel kernels (blur, gradient, rectify/clip, ...) one at a time, in fixed order, over a full frame each. It drives each kernel's run, watches its done, and clears kernel coordinate state between frames. It also drives the frame-buffer source/destination selects so that each pass reads and writes distinct buffers.

Parameters:
NUM_PASSES, 3, number of kernels sequenced; range 1..8
PASS_BITS, 2, width of pass index; must satisfy 2^PASS_BITS >= NUM_PASSES
CNT_BITS, 32, width of the cycle counter (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request to process one frame; honoured only in IDLE
abort  in  1  terminate the frame in progress
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the last pass has completed
aborted  out  1  one-cycle pulse when an abort has been taken
kern_run  out  NUM_PASSES  one-hot run to the kernels; all zero outside RUN
kern_done  in  NUM_PASSES  done from each kernel
kern_rst_n  out  1  registered, active-low clear to all kernels
pass_idx  out  PASS_BITS  index of the current or most recent pass
src_sel  out  2  source frame buffer: 0=input, 1=scratch A, 2=scratch B
dst_sel  out  2  destination frame buffer: 1 or 2
out_sel  out  2  buffer holding the final result; valid once frame_done pulses
frame_cycles  out  CNT_BITS  cycles from start to frame_done (optional feature only)

Behaviour:
- Reset values: state=IDLE, busy=0, frame_done=0, aborted=0, kern_run=0, kern_rst_n=1, pass_idx=0, src_sel=0, dst_sel=1, out_sel=0, frame_cycles=0.
- All outputs are registered; there is no combinational path from any input to any output.
- States and transitions:
  - IDLE: start & ~abort -> CLEAR.
  - CLEAR: kern_rst_n=0 for exactly 1 cycle; pass_idx=0; then -> RUN.
  - RUN: kern_run[pass_idx]=1. kern_done[pass_idx] sampled high marks the last-pixel cycle (the kernel writes that pixel this cycle). Then:
    - -> GAP if pass_idx < NUM_PASSES-1;
    - -> FINISH otherwise.
  - GAP: 1 cycle with kern_run=0; pass_idx increments; selects update; then -> RUN.
  - FINISH: frame_done=1 for 1 cycle; out_sel=dst_sel of the last pass; then -> IDLE.
  - ABORT: entered from CLEAR, RUN or GAP when abort=1. kern_run=0 and kern_rst_n=0 for 1 cycle; aborted=1; then -> IDLE. out_sel is unchanged.
- Select schedule for pass p:
  - dst_sel = 1 + (p mod 2).
  - src_sel = 0 if p=0, else 1 + ((p-1) mod 2).
  - src_sel never equals dst_sel.
  - Selects are stable for the whole RUN and change only in CLEAR/GAP.
- Done handling:
  - kern_done bits of inactive passes are ignored.
  - If kern_done[pass_idx] is already high on RUN entry, the pass lasts 1 cycle (1x1 image).
- Latency: start sampled at cycle t; CLEAR at t+1; pass 0 RUN starts at t+2. Each pass takes P cycles (P = pixels per frame), with 1 GAP cycle between passes. frame_done is at t+2+NUM_PASSES*P+(NUM_PASSES-1).
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start and abort in the same cycle in IDLE: nothing happens.
  - abort in FINISH: ignored; the frame completes.
  - abort in IDLE: ignored.
  - rst_n asserted mid-frame: immediate return to reset values; no frame_done pulse.

Optional Feature:
PASS_SEQ_CYCLE_CNT_EN.
- Defined:
  - Counter clears on CLEAR entry and increments every busy cycle.
  - frame_cycles captures the count in FINISH and holds it until the next FINISH.
  - The counter saturates at all-ones.
  - ABORT does not update frame_cycles.
- Undefined: the frame_cycles port and the counter logic are absent.

Decomposition:
- Shared package edge_pkg:
  - seq_state_t enum (IDLE, CLEAR, RUN, GAP, FINISH, ABORT);
  - fb_sel_t (2-bit) with constants FB_INPUT=0, FB_SCRATCH_A=1, FB_SCRATCH_B=2.
- One sub-module, fb_sel_sched: combinational map from pass index to {src_sel, dst_sel}; registered in the parent.

Test Plan:
- Kernel stubs assert done after P=8 cycles of run; NUM_PASSES=3; start at t. Required response:
  - kern_run[0] high t+2..t+9, kern_run[1] high t+11..t+18, kern_run[2] high t+20..t+27;
  - frame_done pulses at t+28; out_sel=1;
  - frame_cycles=28 when PASS_SEQ_CYCLE_CNT_EN is defined.
- Selects per pass: src/dst = 0/1, 1/2, 2/1 across passes 0..2; never equal on any cycle; kern_rst_n low only at t+1.
- abort asserted at cycle t+14, during pass 1: aborted pulses at t+15 with kern_run=0 and kern_rst_n=0 at t+15; IDLE at t+16; frame_done never pulses.
- start pulsed at t+5 and t+20 while busy: no effect; a start after frame_done begins a new frame with kern_rst_n low one cycle later.
- P=1 (done already high on RUN entry) with NUM_PASSES=1: kern_run high 1 cycle at t+2; frame_done at t+3.
- rst_n deasserted during the pass 0 RUN: all outputs return to reset values immediately; a subsequent start behaves as in the first scenario.
